// File: rtl/bindct_8pt_pipe.sv
// bindct_8pt_pipe: 8-point binary (lifting) DCT. It has four register stages and a
// single pipeline enable driven by output backpressure.
// Ports:
//   clk, rst (synchronous, active-low)
//   in_valid/in_ready/x_in[0:7]   : input vector handshake; in_ready is combinational
//   out_valid/out_ready/y_out[0:7]: output coefficient handshake
//   sat_flag (sticky clip indicator), clr_sat (clears it; a new clip wins)
module bindct_8pt_pipe #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 12,
  parameter int unsigned FRAC_BITS = 6,
  parameter int unsigned K1 = 26,
  parameter int unsigned K2 = 48,
  parameter int unsigned K3 = 26,
  parameter int unsigned K4 = 24,
  parameter int unsigned K5 = 12,
  parameter int unsigned K6 = 12,
  parameter int unsigned K7 = 51,
  parameter int unsigned K8 = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  x_in [0:7],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] y_out [0:7],
  output logic                        sat_flag,
  input  logic                        clr_sat
);
  localparam int unsigned IW = IN_WIDTH + 4;
  localparam int unsigned KW = 16;
  localparam int unsigned PW = IW + KW + 1;
  localparam int unsigned SW = (IW > OUT_WIDTH) ? IW : OUT_WIDTH;
  localparam logic signed [SW-1:0] OMAX = SW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] OMIN = ~OMAX;

  // Lifting multiply: floor((v*k) / 2^FRAC_BITS), wrapped back to the datapath width
  function automatic logic signed [IW-1:0] mul_k(input logic signed [IW-1:0] v,
                                                 input int unsigned k);
    logic signed [PW-1:0] p;
    p = PW'(v) * $signed(PW'(k));
    p = p >>> FRAC_BITS;
    return p[IW-1:0];
  endfunction

  // Clip to the output range; MSB of the result flags a clip
  function automatic logic [OUT_WIDTH:0] sat_k(input logic signed [IW-1:0] v);
    logic signed [SW-1:0] ve;
    ve = SW'(v);
    if (ve > OMAX) return {1'b1, OMAX[OUT_WIDTH-1:0]};
    if (ve < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
    return {1'b0, ve[OUT_WIDTH-1:0]};
  endfunction

  logic en;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic out_valid_q, out_valid_d, sat_flag_q, sat_flag_d;
  logic signed [IW-1:0] a_q [4], a_d [4], b_q [4], b_d [4];
  logic signed [IW-1:0] c_q [4], c_d [4];
  logic signed [IW-1:0] q1_q, q1_d, q2_q, q2_d, pb0_q, pb0_d, pb3_q, pb3_d;
  logic signed [IW-1:0] ev_q [4], ev_d [4];  // y0, y2, y4, y6
  logic signed [IW-1:0] e_q [4], e_d [4];
  logic signed [IW-1:0] raw [8];
  logic signed [OUT_WIDTH-1:0] y_q [8], y_d [8];

  // The whole pipe advances only when the output slot is free or being drained
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;
  assign y_out     = y_q;

  // Stage 1: butterflies
  always_comb begin : stage1
    v1_d = v1_q;
    a_d  = a_q;
    b_d  = b_q;
    if (en) begin
      v1_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          a_d[i] = IW'(x_in[i]) + IW'(x_in[7-i]);
          b_d[i] = IW'(x_in[i]) - IW'(x_in[7-i]);
        end
      end
    end
  end

  // Stage 2: even butterflies and the b1/b2 lifting pair
  always_comb begin : stage2
    logic signed [IW-1:0] t;
    t     = b_q[2] - mul_k(b_q[1], K1);
    v2_d  = v2_q;
    c_d   = c_q;
    q1_d  = q1_q;
    q2_d  = q2_q;
    pb0_d = pb0_q;
    pb3_d = pb3_q;
    if (en) begin
      v2_d = v1_q;
      if (v1_q) begin
        c_d[0] = a_q[0] + a_q[3];
        c_d[1] = a_q[1] + a_q[2];
        c_d[2] = a_q[1] - a_q[2];
        c_d[3] = a_q[0] - a_q[3];
        q1_d   = t;
        q2_d   = b_q[1] + mul_k(t, K2);
        pb0_d  = b_q[0];
        pb3_d  = b_q[3];
      end
    end
  end

  // Stage 3: even outputs and odd butterflies
  always_comb begin : stage3
    logic signed [IW-1:0] y0, y6;
    y0   = c_q[0] + c_q[1];
    y6   = c_q[2] - mul_k(c_q[3], K3);
    v3_d = v3_q;
    ev_d = ev_q;
    e_d  = e_q;
    if (en) begin
      v3_d = v2_q;
      if (v2_q) begin
        ev_d[0] = y0;
        ev_d[1] = c_q[3] + mul_k(y6, K4);
        ev_d[2] = (y0 >>> 1) - c_q[1];
        ev_d[3] = y6;
        e_d[0]  = pb0_q + q1_q;
        e_d[1]  = pb0_q - q1_q;
        e_d[2]  = pb3_q - q2_q;
        e_d[3]  = pb3_q + q2_q;
      end
    end
  end

  // Stage 4: odd lifting, saturation, output register and sticky clip flag
  always_comb begin : stage4
    logic [OUT_WIDTH:0] s;
    logic clip_any;
    raw[0] = ev_q[0];
    raw[2] = ev_q[1];
    raw[4] = ev_q[2];
    raw[6] = ev_q[3];
    raw[7] = mul_k(e_q[3], K5) - e_q[0];
    raw[1] = e_q[3] - mul_k(raw[7], K6);
    raw[5] = e_q[1] + mul_k(e_q[2], K7);
    raw[3] = e_q[2] - mul_k(raw[5], K8);
    clip_any    = 1'b0;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    for (int k = 0; k < 8; k++) begin
      s = sat_k(raw[k]);
      clip_any = clip_any | s[OUT_WIDTH];
      if (en && v3_q) y_d[k] = s[OUT_WIDTH-1:0];
    end
    if (en) out_valid_d = v3_q;
    // Set has priority over clear
    sat_flag_d = clr_sat ? 1'b0 : sat_flag_q;
    if (en && v3_q && clip_any) sat_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      c_q         <= '{default: '0};
      q1_q        <= '0;
      q2_q        <= '0;
      pb0_q       <= '0;
      pb3_q       <= '0;
      ev_q        <= '{default: '0};
      e_q         <= '{default: '0};
      y_q         <= '{default: '0};
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      pb0_q       <= pb0_d;
      pb3_q       <= pb3_d;
      ev_q        <= ev_d;
      e_q         <= e_d;
      y_q         <= y_d;
    end
  end

endmodule

// File: tb/tb_bindct_8pt_pipe.sv
// Bench for bindct_8pt_pipe: default instance (12-bit out) plus a 10-bit-out twin sharing stimulus.
module tb_bindct_8pt_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, out_ready, clr_sat;
  logic in_ready, out_valid, sat_flag;
  logic in_ready_s, out_valid_s, sat_flag_s;
  logic signed [7:0]  x_in [0:7];
  logic signed [11:0] y12 [0:7];
  logic signed [9:0]  y10 [0:7];

  int chk = 0;
  int fails = 0;

  bindct_8pt_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y12),
    .sat_flag(sat_flag), .clr_sat(clr_sat));

  bindct_8pt_pipe #(.OUT_WIDTH(10)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .x_in(x_in),
    .out_valid(out_valid_s), .out_ready(out_ready), .y_out(y10),
    .sat_flag(sat_flag_s), .clr_sat(clr_sat));

  task automatic check(input string name, input longint act, input longint exp);
    chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic, 12-bit datapath) ----------------
  function automatic longint wr(input longint v);
    longint r;
    r = v & 64'sd4095;
    return (r >= 2048) ? r - 4096 : r;
  endfunction

  function automatic longint mk(input longint v, input longint k);
    return wr((v * k) >>> 6);
  endfunction

  function automatic logic [127:0] model_raw(input logic [63:0] xv);
    longint x [8];
    longint a [4];
    longint b [4];
    longint y [8];
    longint c0, c1, c2, c3, t, q1, q2, e0, e1, e2, e3;
    logic [127:0] r;
    for (int i = 0; i < 8; i++) x[i] = longint'($signed(xv[i*8 +: 8]));
    for (int i = 0; i < 4; i++) begin
      a[i] = wr(x[i] + x[7-i]);
      b[i] = wr(x[i] - x[7-i]);
    end
    c0 = wr(a[0] + a[3]); c1 = wr(a[1] + a[2]);
    c2 = wr(a[1] - a[2]); c3 = wr(a[0] - a[3]);
    t  = wr(b[2] - mk(b[1], 26));
    q2 = wr(b[1] + mk(t, 48));
    q1 = t;
    y[0] = wr(c0 + c1);
    y[4] = wr((y[0] >>> 1) - c1);
    y[6] = wr(c2 - mk(c3, 26));
    y[2] = wr(c3 + mk(y[6], 24));
    e0 = wr(b[0] + q1); e1 = wr(b[0] - q1);
    e2 = wr(b[3] - q2); e3 = wr(b[3] + q2);
    y[7] = wr(mk(e3, 12) - e0);
    y[1] = wr(e3 - mk(y[7], 12));
    y[5] = wr(e1 + mk(e2, 51));
    y[3] = wr(e2 - mk(y[5], 28));
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(y[i]);
    return r;
  endfunction

  function automatic longint raw_y(input logic [127:0] r, input int i);
    return longint'($signed(r[i*16 +: 16]));
  endfunction

  function automatic longint sat_y(input longint v, input int ow);
    longint hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic logic clipped(input logic [127:0] r, input int ow);
    logic c;
    c = 1'b0;
    for (int i = 0; i < 8; i++) if (sat_y(raw_y(r, i), ow) != raw_y(r, i)) c = 1'b1;
    return c;
  endfunction

  function automatic logic [63:0] pk(input int v0, v1, v2, v3, v4, v5, v6, v7);
    return {8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  function automatic logic [63:0] dc(input int v);
    return pk(v, v, v, v, v, v, v, v);
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [63:0] sb [$];
  logic prev_ov = 1'b0, prev_or = 1'b1, prev_clr = 1'b0;
  logic exp_s12 = 1'b0, exp_s10 = 1'b0;
  int n_acc = 0, n_out = 0;

  always @(negedge clk) begin : mon
    logic [63:0] xv;
    logic [127:0] r;
    logic newp;
    if (!rst) begin
      sb.delete();
      exp_s12 = 1'b0; exp_s10 = 1'b0;
      prev_ov = 1'b0; prev_or = 1'b1; prev_clr = 1'b0;
    end else begin
      check("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
      check("twin_out_valid", longint'(out_valid_s), longint'(out_valid));
      // A result freshly loaded at the last edge may set the sticky flag; a pending clear yields
      newp = out_valid && (!prev_ov || prev_or);
      if (prev_clr) begin exp_s12 = 1'b0; exp_s10 = 1'b0; end
      if (out_valid) begin
        check("out_has_expected", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          r = model_raw(sb[0]);
          for (int i = 0; i < 8; i++) begin
            check($sformatf("y12[%0d]", i), longint'(y12[i]), sat_y(raw_y(r, i), 12));
            check($sformatf("y10[%0d]", i), longint'(y10[i]), sat_y(raw_y(r, i), 10));
          end
          if (newp && clipped(r, 12)) exp_s12 = 1'b1;
          if (newp && clipped(r, 10)) exp_s10 = 1'b1;
        end
      end
      check("sat_flag12", longint'(sat_flag), longint'(exp_s12));
      check("sat_flag10", longint'(sat_flag_s), longint'(exp_s10));
      if (out_valid && out_ready && sb.size() > 0) begin
        void'(sb.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < 8; i++) xv[i*8 +: 8] = x_in[i];
        sb.push_back(xv);
        n_acc++;
      end
      prev_ov = out_valid; prev_or = out_ready; prev_clr = clr_sat;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input logic [63:0] xv);
    for (int i = 0; i < 8; i++) x_in[i] = xv[i*8 +: 8];
  endtask

  // Present one vector into an empty pipe and count edges until out_valid
  task automatic lat_test(input logic [63:0] xv, input string name);
    int lat;
    set_x(xv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 4);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [127:0] r;
    logic [63:0] tv [4];
    longint pin_imp1 [8];
    longint pin_imp64 [8];
    longint snap [8];
    pin_imp1  = '{1, 1, 1, 0, 0, 1, 0, -1};
    pin_imp64 = '{64, 12, 54, -28, 32, 64, -26, -64};
    tv[0] = pk(1, 0, 0, 0, 0, 0, 0, 0);
    tv[1] = pk(64, 0, 0, 0, 0, 0, 0, 0);
    tv[2] = pk(0, 1, 2, 3, 4, 5, 6, 7);
    tv[3] = pk(-100, 50, -25, 120, -128, 7, 99, -60);

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sat = 1'b0;
    set_x('0);
    repeat (3) tick();
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_valid_s", longint'(out_valid_s), 0);
    check("rst_sat_flag", longint'(sat_flag), 0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_y[%0d]", i), longint'(y12[i]), 0);
    rst = 1'b1;
    #1;
    check("in_ready_after_rst", longint'(in_ready), 1);

    // Model pins against hand-derived values
    r = model_raw(dc(16));
    check("pin_dc16_y0", raw_y(r, 0), 128);
    for (int i = 0; i < 8; i++) begin
      r = model_raw(tv[0]);
      check($sformatf("pin_imp1_y%0d", i), raw_y(r, i), pin_imp1[i]);
      r = model_raw(tv[1]);
      check($sformatf("pin_imp64_y%0d", i), raw_y(r, i), pin_imp64[i]);
    end
    r = model_raw(dc(127));
    check("pin_dc127_sat10", sat_y(raw_y(r, 0), 10), 511);

    // DC vectors with exact latency
    lat_test(dc(16), "dc16");
    check("dc16_y0", longint'(y12[0]), 128);
    for (int i = 1; i < 8; i++) check($sformatf("dc16_y%0d", i), longint'(y12[i]), 0);
    tick();
    lat_test(dc(-128), "dcm128");
    check("dcm128_y0", longint'(y12[0]), -1024);
    for (int i = 1; i < 8; i++) check($sformatf("dcm128_y%0d", i), longint'(y12[i]), 0);
    tick();

    // Back-to-back throughput: results on T+4..T+7
    for (int k = 0; k < 4; k++) begin
      set_x(tv[k]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("tput_ov0", longint'(out_valid), 1);
    check("tput_first_y0", longint'(y12[0]), 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("tput_ov%0d", k), longint'(out_valid), 1);
    end
    tick();
    check("tput_ov_end", longint'(out_valid), 0);

    // Backpressure: 3-cycle stall while streaming
    fork
      begin : sender
        for (int k = 0; k < 8; k++) begin
          logic acc;
          set_x(pk(k * 10 - 40, 3 * k, -k, 100 - k, k, -7 * k, 2, k - 90));
          in_valid = 1'b1;
          acc = 1'b0;
          for (int w = 0; w < 20 && !acc; w++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
          end
          check("bp_accepted", longint'(acc), 1);
        end
        in_valid = 1'b0;
      end
      begin : stall
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
          tick();
          w++;
        end
        check("bp_ov_seen", longint'(out_valid), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) snap[i] = longint'(y12[i]);
        for (int s = 0; s < 3; s++) begin
          #1;
          check("bp_in_ready_low", longint'(in_ready), 0);
          check("bp_ov_held", longint'(out_valid), 1);
          for (int i = 0; i < 8; i++) check("bp_y_stable", longint'(y12[i]), snap[i]);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) tick();
    check("bp_count", longint'(n_out), longint'(n_acc));
    check("bp_sb_empty", longint'(sb.size()), 0);

    // Saturation on the 10-bit twin
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    check("sat_cleared_pre", longint'(sat_flag_s), 0);
    lat_test(dc(127), "sat");
    check("sat_y0", longint'(y10[0]), 511);
    check("sat_flag_set", longint'(sat_flag_s), 1);
    check("sat_flag12_clear", longint'(sat_flag), 0);
    repeat (3) tick();
    check("sat_flag_held", longint'(sat_flag_s), 1);
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    check("sat_flag_clr", longint'(sat_flag_s), 0);
    // Clear held high while a clipping result lands: set wins
    clr_sat = 1'b1;
    lat_test(dc(127), "sat_win");
    check("sat_set_wins", longint'(sat_flag_s), 1);
    clr_sat = 1'b0;
    tick();
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    check("sat_flag_clr2", longint'(sat_flag_s), 0);

    // Reset with 3 vectors in flight
    for (int k = 0; k < 3; k++) begin
      set_x(tv[k]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rst_mid_no_out", longint'(out_valid), 0);
    end
    lat_test(tv[1], "post_rst");
    check("post_rst_y2", longint'(y12[2]), 54);
    check("post_rst_y3", longint'(y12[3]), -28);
    repeat (5) tick();
    check("final_sb_empty", longint'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end
endmodule

// File: doc/bindct_8pt_pipe.md
BINDCT_8PT_PIPE -- requirements
Module: bindct_8pt_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IN_WIDTH, 8, signed input sample width.
- OUT_WIDTH, 12, signed output coefficient width.
- FRAC_BITS, 6, fraction bits of the lifting constants.
- K1..K8, 26/48/26/24/12/12/51/28, unsigned lifting constants, each in units of 2^-FRAC_BITS.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- in_valid, in, 1, x_in holds a vector.
- in_ready, out, 1, block accepts a vector this cycle.
- x_in[0:7], in, IN_WIDTH each, signed samples.
- out_valid, out, 1, y_out holds a result.
- out_ready, in, 1, downstream accepts a result.
- y_out[0:7], out, OUT_WIDTH each, signed coefficients.
- sat_flag, out, 1, sticky saturation indicator.
- clr_sat, in, 1, clears sat_flag.

REQ-003 Reset SHALL be rst, synchronous, active-low; the clock SHALL be clk.

Function
REQ-004 The internal datapath width SHALL be IW = IN_WIDTH+4, with inputs sign-extended to IW.
REQ-005 M(v,K) SHALL be (v*K) arithmetically shifted right by FRAC_BITS (floor), truncated to IW.
REQ-006 Stage 1 SHALL compute a_i = x_i + x_(7-i) and b_i = x_i - x_(7-i) for i = 0..3.
REQ-007 Stage 2 SHALL compute:
- c0 = a0+a3, c1 = a1+a2, c2 = a1-a2, c3 = a0-a3.
- t = b2 - M(b1,K1), q2 = b1 + M(t,K2), q1 = t.
- b0 and b3 SHALL pass through unchanged.
REQ-008 Stage 3 SHALL compute:
- y0 = c0+c1, y4 = (y0>>>1) - c1.
- y6 = c2 - M(c3,K3), y2 = c3 + M(y6,K4).
- e0 = b0+q1, e1 = b0-q1, e2 = b3-q2, e3 = b3+q2.
REQ-009 Stage 4 SHALL compute:
- y7 = M(e3,K5) - e0, y1 = e3 - M(y7,K6).
- y5 = e1 + M(e2,K7), y3 = e2 - M(y5,K8).
- Each y_k SHALL then saturate to the OUT_WIDTH signed range and register onto y_out.
REQ-010 Each stage SHALL be one register level, giving latency exactly 4 cycles from an accepted vector to out_valid when there is no stall.
REQ-011 The pipeline enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-012 A vector SHALL be accepted only on a cycle with in_valid && in_ready; x_in is ignored otherwise.
REQ-013 When en=0, all stage registers, valid bits, out_valid and y_out SHALL hold unchanged.
REQ-014 When en=1, every stage valid bit SHALL shift forward; bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-015 The block SHALL sustain 1 vector/cycle when in_valid and out_ready are held high, with results in acceptance order.
REQ-016 out_valid SHALL remain high, with y_out stable, until the cycle out_ready=1.
REQ-017 sat_flag SHALL set on any cycle where stage-4 data is valid and enabled and any y_k is clipped.
REQ-018 clr_sat=1 SHALL clear sat_flag next cycle; simultaneous set and clr SHALL leave sat_flag=1 (set wins).
REQ-019 With OUT_WIDTH >= IW, saturation SHALL never occur.
REQ-020 The datapath SHALL be state-free between vectors; results depend only on the vector and the parameters.

Reset
REQ-021 While rst=0 at a clk edge:
- all stage valid bits, out_valid and sat_flag SHALL be 0.
- y_out and the stage data registers SHALL be 0.
REQ-022 in_ready SHALL be 1 in the first cycle after reset release.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight vectors, and no result for them SHALL appear afterwards.

Verification
REQ-024 Reset: hold rst=0 for 3 cycles -> out_valid=0, sat_flag=0, y_out all 0, in_ready=1 after release.
REQ-025 DC inputs:
- all x=16 accepted at cycle T -> out_valid at T+4 with y0=128 and y1..y7=0.
- all x=-128 -> y0=-1024, others 0.
REQ-026 Throughput: 4 vectors on consecutive cycles with out_ready=1 -> 4 results on cycles T+4..T+7, in order, each matching a bench model of REQ-005..REQ-009.
REQ-027 Backpressure: drop out_ready for 3 cycles while out_valid=1 ->
- in_ready=0 and y_out stable during the stall;
- no vector lost or duplicated after out_ready returns.
REQ-028 Saturation: override OUT_WIDTH=10, drive all x=127 ->
- y0=511 and sat_flag=1, held until clr_sat;
- clr_sat pulse -> sat_flag=0.
REQ-029 Reset mid-operation: assert rst with 3 vectors in flight -> no out_valid pulse after release until a new vector is accepted, which appears 4 cycles later.
